// File: rtl/wb_unit_pkg.sv
// rtl/wb_unit_pkg.sv - shared codes and state type for the write-back stage
package wb_unit_pkg;

    // Result source select
    localparam logic [1:0] WB_SEL_ALU  = 2'b00;
    localparam logic [1:0] WB_SEL_LOAD = 2'b01;
    localparam logic [1:0] WB_SEL_PC4  = 2'b10;
    localparam logic [1:0] WB_SEL_CSR  = 2'b11;

    // Load size/sign encodings (funct3)
    localparam logic [2:0] LOAD_F3_LB  = 3'b000;
    localparam logic [2:0] LOAD_F3_LH  = 3'b001;
    localparam logic [2:0] LOAD_F3_LW  = 3'b010;
    localparam logic [2:0] LOAD_F3_LBU = 3'b100;
    localparam logic [2:0] LOAD_F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRITE  = 2'd1,
        COMMIT = 2'd2,
        HALT   = 2'd3
    } wb_state_t;

endpackage

// File: rtl/wb_load_ext.sv
// rtl/wb_load_ext.sv - load data field select and sign/zero extension
//   funct3  in  3   load size/sign code
//   offset  in  2   byte offset within the word
//   word    in  32  word-aligned load data
//   data    out 32  extended result (0 for unknown funct3)
module wb_load_ext
    import wb_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] data
);

    logic [7:0]  byte_val;
    logic [15:0] half_val;

    always_comb begin
        byte_val = 8'd0;
        case (offset)
            2'd0: byte_val = word[7:0];
            2'd1: byte_val = word[15:8];
            2'd2: byte_val = word[23:16];
            2'd3: byte_val = word[31:24];
            default: byte_val = 8'd0;
        endcase
        // Halfwords are selected by offset[1] only; offset[0] is ignored.
        half_val = offset[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data = 32'd0;
        case (funct3)
            LOAD_F3_LB:  data = {{24{byte_val[7]}}, byte_val};
            LOAD_F3_LBU: data = {24'd0, byte_val};
            LOAD_F3_LH:  data = {{16{half_val[15]}}, half_val};
            LOAD_F3_LHU: data = {16'd0, half_val};
            LOAD_F3_LW:  data = word;
            default:     data = 32'd0;
        endcase
    end

endmodule

// File: rtl/wb_unit.sv
// rtl/wb_unit.sv - write-back stage: regfile write, PC commit, instret, ebreak halt
//   clk, rst                    clock, synchronous active-high reset
//   lsu_i_*                     retiring instruction fields, valid/ready handshake with wb_o_ready
//   write_back_o_reg_wen/rd/data regfile write port, asserted for one cycle
//   commit_o_valid/dnpc, commit_i_ready  next-PC handshake to the IFU
//   wb_o_halt                   sticky, set once ebreak retires
//   wb_o_instret                64-bit retired-instruction counter
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_i_valid,
    output logic                  wb_o_ready,
    input  logic                  lsu_i_reg_wen,
    input  logic [REG_ADDR_W-1:0] lsu_i_reg_rd,
    input  logic [1:0]            lsu_i_wb_sel,
    input  logic [XLEN-1:0]       lsu_i_alu_res,
    input  logic [XLEN-1:0]       lsu_i_mem_rdata,
    input  logic [XLEN-1:0]       lsu_i_csr_rdata,
    input  logic [2:0]            lsu_i_funct3,
    input  logic [XLEN-1:0]       lsu_i_pc,
    input  logic [XLEN-1:0]       lsu_i_dnpc,
    input  logic                  lsu_i_ebreak,
    output logic                  write_back_o_reg_wen,
    output logic [REG_ADDR_W-1:0] write_back_o_reg_rd,
    output logic [XLEN-1:0]       write_back_o_reg_data,
    output logic                  commit_o_valid,
    input  logic                  commit_i_ready,
    output logic [XLEN-1:0]       commit_o_dnpc,
    output logic                  wb_o_halt,
    output logic [63:0]           wb_o_instret
);

    wb_state_t state, state_next;

    logic                  wen_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [1:0]            sel_q;
    logic [XLEN-1:0]       alu_q;
    logic [XLEN-1:0]       rdata_q;
    logic [XLEN-1:0]       csr_q;
    logic [2:0]            funct3_q;
    logic [XLEN-1:0]       pc_q;
    logic [XLEN-1:0]       dnpc_q;
    logic                  ebreak_q;

    logic [XLEN-1:0]       load_data;
    logic [XLEN-1:0]       result;
    logic                  accept;
    logic                  retire;

    wb_load_ext u_load_ext (
        .funct3 (funct3_q),
        .offset (alu_q[1:0]),
        .word   (rdata_q),
        .data   (load_data)
    );

    always_comb begin
        result = '0;
        case (sel_q)
            WB_SEL_ALU:  result = alu_q;
            WB_SEL_LOAD: result = load_data;
            WB_SEL_PC4:  result = pc_q + XLEN'(4);
            WB_SEL_CSR:  result = csr_q;
            default:     result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Every output is qualified by !rst so an instruction in flight when
    // reset arrives can neither write the regfile nor commit.
    always_comb begin
        state_next            = state;
        wb_o_ready            = 1'b0;
        write_back_o_reg_wen  = 1'b0;
        write_back_o_reg_rd   = '0;
        write_back_o_reg_data = '0;
        commit_o_valid        = 1'b0;
        commit_o_dnpc         = '0;
        wb_o_halt             = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    wb_o_ready = 1'b1;
                    if (lsu_i_valid) state_next = WRITE;
                end
                WRITE: begin
                    write_back_o_reg_wen  = wen_q && (rd_q != '0);
                    write_back_o_reg_rd   = rd_q;
                    write_back_o_reg_data = result;
                    state_next            = ebreak_q ? HALT : COMMIT;
                end
                COMMIT: begin
                    commit_o_valid = 1'b1;
                    commit_o_dnpc  = dnpc_q;
                    if (commit_i_ready) state_next = IDLE;
                end
                HALT: begin
                    wb_o_halt = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign accept = lsu_i_valid && wb_o_ready;
    // An ebreak retires on its way into HALT since it never commits.
    assign retire = (commit_o_valid && commit_i_ready) ||
                    (!rst && state == WRITE && ebreak_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            wen_q    <= 1'b0;
            rd_q     <= '0;
            sel_q    <= WB_SEL_ALU;
            alu_q    <= '0;
            rdata_q  <= '0;
            csr_q    <= '0;
            funct3_q <= '0;
            pc_q     <= '0;
            dnpc_q   <= '0;
            ebreak_q <= 1'b0;
        end else if (accept) begin
            wen_q    <= lsu_i_reg_wen;
            rd_q     <= lsu_i_reg_rd;
            sel_q    <= lsu_i_wb_sel;
            alu_q    <= lsu_i_alu_res;
            rdata_q  <= lsu_i_mem_rdata;
            csr_q    <= lsu_i_csr_rdata;
            funct3_q <= lsu_i_funct3;
            pc_q     <= lsu_i_pc;
            dnpc_q   <= lsu_i_dnpc;
            ebreak_q <= lsu_i_ebreak;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_o_instret <= 64'd0;
        end else if (retire) begin
            wb_o_instret <= wb_o_instret + 64'd1;
        end
    end

endmodule

// File: tb/tb_wb_unit.sv
// tb/tb_wb_unit.sv - self-checking bench for wb_unit
module tb_wb_unit;

    logic        clk;
    logic        rst;
    logic        lsu_i_valid;
    logic        wb_o_ready;
    logic        lsu_i_reg_wen;
    logic [4:0]  lsu_i_reg_rd;
    logic [1:0]  lsu_i_wb_sel;
    logic [31:0] lsu_i_alu_res;
    logic [31:0] lsu_i_mem_rdata;
    logic [31:0] lsu_i_csr_rdata;
    logic [2:0]  lsu_i_funct3;
    logic [31:0] lsu_i_pc;
    logic [31:0] lsu_i_dnpc;
    logic        lsu_i_ebreak;
    logic        write_back_o_reg_wen;
    logic [4:0]  write_back_o_reg_rd;
    logic [31:0] write_back_o_reg_data;
    logic        commit_o_valid;
    logic        commit_i_ready;
    logic [31:0] commit_o_dnpc;
    logic        wb_o_halt;
    logic [63:0] wb_o_instret;

    wb_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .lsu_i_valid           (lsu_i_valid),
        .wb_o_ready            (wb_o_ready),
        .lsu_i_reg_wen         (lsu_i_reg_wen),
        .lsu_i_reg_rd          (lsu_i_reg_rd),
        .lsu_i_wb_sel          (lsu_i_wb_sel),
        .lsu_i_alu_res         (lsu_i_alu_res),
        .lsu_i_mem_rdata       (lsu_i_mem_rdata),
        .lsu_i_csr_rdata       (lsu_i_csr_rdata),
        .lsu_i_funct3          (lsu_i_funct3),
        .lsu_i_pc              (lsu_i_pc),
        .lsu_i_dnpc            (lsu_i_dnpc),
        .lsu_i_ebreak          (lsu_i_ebreak),
        .write_back_o_reg_wen  (write_back_o_reg_wen),
        .write_back_o_reg_rd   (write_back_o_reg_rd),
        .write_back_o_reg_data (write_back_o_reg_data),
        .commit_o_valid        (commit_o_valid),
        .commit_i_ready        (commit_i_ready),
        .commit_o_dnpc         (commit_o_dnpc),
        .wb_o_halt             (wb_o_halt),
        .wb_o_instret          (wb_o_instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  f3;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [31:0] csr;
        logic [31:0] pc;
        logic [31:0] dnpc;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp_data;
        logic        exp_wen;
    } vec_t;

    localparam int NV = 14;
    vec_t  vecs [NV];
    int    checks;
    int    errors;
    logic [63:0] exp_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        for (int k = 0; k < 10 && wb_o_ready !== 1'b1; k++) step();
        chk("ready_wait", {63'd0, wb_o_ready}, 64'd1);
    endtask

    // Present one instruction and hold it for the accepting edge.
    task automatic drive(input vec_t v, input logic ebreak);
        wait_ready();
        lsu_i_valid     = 1'b1;
        lsu_i_reg_wen   = v.wen;
        lsu_i_reg_rd    = v.rd;
        lsu_i_wb_sel    = v.sel;
        lsu_i_alu_res   = v.alu;
        lsu_i_mem_rdata = v.rdata;
        lsu_i_csr_rdata = v.csr;
        lsu_i_funct3    = v.f3;
        lsu_i_pc        = v.pc;
        lsu_i_dnpc      = v.dnpc;
        lsu_i_ebreak    = ebreak;
        step();
        lsu_i_valid     = 1'b0;
        lsu_i_ebreak    = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive(v, 1'b0);
        chk($sformatf("v%0d_wen", i), {63'd0, write_back_o_reg_wen}, {63'd0, v.exp_wen});
        chk($sformatf("v%0d_rd", i), {59'd0, write_back_o_reg_rd}, {59'd0, v.rd});
        chk($sformatf("v%0d_data", i), {32'd0, write_back_o_reg_data}, {32'd0, v.exp_data});
        step();
        chk($sformatf("v%0d_wen_one_cycle", i), {63'd0, write_back_o_reg_wen}, 64'd0);
        chk($sformatf("v%0d_commit_valid", i), {63'd0, commit_o_valid}, 64'd1);
        chk($sformatf("v%0d_dnpc", i), {32'd0, commit_o_dnpc}, {32'd0, v.dnpc});
        step();
        exp_instret = exp_instret + 64'd1;
        chk($sformatf("v%0d_instret", i), wb_o_instret, exp_instret);
        chk($sformatf("v%0d_idle_ready", i), {63'd0, wb_o_ready}, 64'd1);
    endtask

    initial begin
        vec_t v;
        checks = 0;
        errors = 0;
        exp_instret = 64'd0;
        //            sel    f3      alu           rdata         csr           pc            dnpc          rd  wen  exp_data      exp_wen
        vecs[0]  = '{2'b00, 3'b000, 32'h1234_5678, 32'h0,        32'h0,        32'h0000_0100, 32'h0000_0104, 5'd5, 1'b1, 32'h1234_5678, 1'b1};
        vecs[1]  = '{2'b01, 3'b000, 32'h0000_0003, 32'h80FF_0000, 32'h0,       32'h0000_0104, 32'h0000_0108, 5'd6, 1'b1, 32'hFFFF_FF80, 1'b1};
        vecs[2]  = '{2'b01, 3'b100, 32'h0000_0003, 32'h80FF_0000, 32'h0,       32'h0000_0108, 32'h0000_010C, 5'd6, 1'b1, 32'h0000_0080, 1'b1};
        vecs[3]  = '{2'b01, 3'b001, 32'h0000_0002, 32'h80FF_0000, 32'h0,       32'h0000_010C, 32'h0000_0110, 5'd7, 1'b1, 32'hFFFF_80FF, 1'b1};
        vecs[4]  = '{2'b01, 3'b101, 32'h0000_0003, 32'h80FF_0000, 32'h0,       32'h0000_0110, 32'h0000_0114, 5'd7, 1'b1, 32'h0000_80FF, 1'b1};
        vecs[5]  = '{2'b01, 3'b010, 32'h0000_0001, 32'hDEAD_BEEF, 32'h0,       32'h0000_0114, 32'h0000_0118, 5'd8, 1'b1, 32'hDEAD_BEEF, 1'b1};
        vecs[6]  = '{2'b01, 3'b000, 32'h0000_0000, 32'h0000_007F, 32'h0,       32'h0000_0118, 32'h0000_011C, 5'd9, 1'b1, 32'h0000_007F, 1'b1};
        vecs[7]  = '{2'b01, 3'b001, 32'h0000_0000, 32'h1234_8001, 32'h0,       32'h0000_011C, 32'h0000_0120, 5'd9, 1'b1, 32'hFFFF_8001, 1'b1};
        vecs[8]  = '{2'b01, 3'b011, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0,       32'h0000_0120, 32'h0000_0124, 5'd10, 1'b1, 32'h0000_0000, 1'b1};
        vecs[9]  = '{2'b11, 3'b000, 32'h0,         32'h0,         32'hCAFE_F00D, 32'h0000_0124, 32'h0000_0128, 5'd11, 1'b1, 32'hCAFE_F00D, 1'b1};
        vecs[10] = '{2'b10, 3'b000, 32'h0,         32'h0,         32'h0,       32'hFFFF_FFFC, 32'h0000_2000, 5'd1, 1'b1, 32'h0000_0000, 1'b1};
        vecs[11] = '{2'b10, 3'b000, 32'h0,         32'h0,         32'h0,       32'h0000_1000, 32'h0000_1004, 5'd1, 1'b1, 32'h0000_1004, 1'b1};
        vecs[12] = '{2'b00, 3'b000, 32'h0000_0055, 32'h0,         32'h0,       32'h0000_2000, 32'h0000_2004, 5'd0, 1'b1, 32'h0000_0055, 1'b0};
        vecs[13] = '{2'b00, 3'b000, 32'h0000_0066, 32'h0,         32'h0,       32'h0000_2004, 32'h0000_2008, 5'd7, 1'b0, 32'h0000_0066, 1'b0};

        rst = 1'b1;
        lsu_i_valid = 1'b1;
        lsu_i_reg_wen = 1'b0;
        lsu_i_reg_rd = 5'd0;
        lsu_i_wb_sel = 2'b00;
        lsu_i_alu_res = 32'd0;
        lsu_i_mem_rdata = 32'd0;
        lsu_i_csr_rdata = 32'd0;
        lsu_i_funct3 = 3'd0;
        lsu_i_pc = 32'd0;
        lsu_i_dnpc = 32'd0;
        lsu_i_ebreak = 1'b0;
        commit_i_ready = 1'b1;

        // Reset state
        step();
        step();
        chk("rst_ready", {63'd0, wb_o_ready}, 64'd0);
        chk("rst_wen", {63'd0, write_back_o_reg_wen}, 64'd0);
        chk("rst_commit_valid", {63'd0, commit_o_valid}, 64'd0);
        chk("rst_halt", {63'd0, wb_o_halt}, 64'd0);
        chk("rst_instret", wb_o_instret, 64'd0);
        lsu_i_valid = 1'b0;
        rst = 1'b0;
        step();
        chk("post_rst_ready", {63'd0, wb_o_ready}, 64'd1);

        for (int i = 0; i < NV; i++) run_vec(i);

        // Commit back-pressure: valid/dnpc held, no new accept
        commit_i_ready = 1'b0;
        v = vecs[0];
        v.dnpc = 32'hABCD_0000;
        drive(v, 1'b0);
        step();
        lsu_i_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_valid", k), {63'd0, commit_o_valid}, 64'd1);
            chk($sformatf("bp%0d_dnpc", k), {32'd0, commit_o_dnpc}, 64'hABCD_0000);
            chk($sformatf("bp%0d_ready", k), {63'd0, wb_o_ready}, 64'd0);
            chk($sformatf("bp%0d_instret", k), wb_o_instret, exp_instret);
            step();
        end
        lsu_i_valid = 1'b0;
        commit_i_ready = 1'b1;
        step();
        exp_instret = exp_instret + 64'd1;
        chk("bp_release_valid", {63'd0, commit_o_valid}, 64'd0);
        chk("bp_release_instret", wb_o_instret, exp_instret);

        // ebreak: HALT, sticky, counted once, never commits
        v = vecs[13];
        drive(v, 1'b1);
        step();
        exp_instret = exp_instret + 64'd1;
        lsu_i_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("halt%0d_halt", k), {63'd0, wb_o_halt}, 64'd1);
            chk($sformatf("halt%0d_commit", k), {63'd0, commit_o_valid}, 64'd0);
            chk($sformatf("halt%0d_ready", k), {63'd0, wb_o_ready}, 64'd0);
            chk($sformatf("halt%0d_instret", k), wb_o_instret, exp_instret);
            step();
        end
        lsu_i_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        exp_instret = 64'd0;
        chk("halt_rst_halt", {63'd0, wb_o_halt}, 64'd0);
        chk("halt_rst_instret", wb_o_instret, exp_instret);
        chk("halt_rst_ready", {63'd0, wb_o_ready}, 64'd1);

        // Reset while in WRITE drops the instruction
        v = vecs[0];
        v.rd = 5'd9;
        drive(v, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstw_wen", {63'd0, write_back_o_reg_wen}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstw%0d_commit", k), {63'd0, commit_o_valid}, 64'd0);
            chk($sformatf("rstw%0d_wen", k), {63'd0, write_back_o_reg_wen}, 64'd0);
            chk($sformatf("rstw%0d_instret", k), wb_o_instret, 64'd0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
